// File: rtl/fp_wb_arbiter.sv
// Round-robin, starvation-escalated arbiter from FPU writeback producers into one output register.
// Latency: ack in the request cycle, out_valid on the next edge; backpressure: no acks while the held result is not taken.
module fp_wb_arbiter #(
   parameter int NUM_UNITS    = 4,
   parameter int PAYLOAD_W    = 80,
   parameter int ID_W         = 3,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_UNITS-1:0]           req_done,
   input  logic [NUM_UNITS*ID_W-1:0]      req_id,
   input  logic [NUM_UNITS*PAYLOAD_W-1:0] req_payload,
   output logic [NUM_UNITS-1:0]           req_ack,
   output logic                           out_valid,
   output logic [ID_W-1:0]                out_id,
   output logic [PAYLOAD_W-1:0]           out_payload,
   output logic [$clog2(NUM_UNITS)-1:0]   out_src,
   input  logic                           out_ready,
   output logic                           starve_active
);

   localparam int SRC_W = $clog2(NUM_UNITS);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef struct packed {
      logic [ID_W-1:0]      id;
      logic [PAYLOAD_W-1:0] payload;
      logic [SRC_W-1:0]     src;
   } hold_t;

   hold_t            hold_q;
   logic [SRC_W-1:0] rr_ptr;
   logic [CNT_W-1:0] wait_cnt [NUM_UNITS];

   logic                 load;
   logic                 starve_hit;
   logic [SRC_W-1:0]     starve_idx;
   logic [SRC_W-1:0]     rr_idx;
   logic [SRC_W-1:0]     grant;
   logic [ID_W-1:0]      sel_id;
   logic [PAYLOAD_W-1:0] sel_payload;

   // base <= NUM_UNITS-1 and k <= NUM_UNITS, so one subtraction always wraps
   function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_UNITS) s = s - NUM_UNITS;
      return SRC_W'(s);
   endfunction

   always_comb begin
      starve_hit = 1'b0;
      starve_idx = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         if (req_done[i] && (wait_cnt[i] == LIMIT)) begin
            starve_hit = 1'b1;
            starve_idx = SRC_W'(i);
         end
      end

      // descending scan so the candidate nearest rr_ptr+1 is written last
      rr_idx = '0;
      for (int k = NUM_UNITS; k >= 1; k--) begin
         if (req_done[wrap_idx(rr_ptr, k)]) rr_idx = wrap_idx(rr_ptr, k);
      end

      grant = starve_hit ? starve_idx : rr_idx;
      load  = (~out_valid | out_ready) & (|req_done);

      req_ack = '0;
      if (load && rst) req_ack[grant] = 1'b1;
      starve_active = starve_hit & load & rst;

      sel_id      = '0;
      sel_payload = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (SRC_W'(i) == grant) begin
            sel_id      = req_id[i*ID_W +: ID_W];
            sel_payload = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         hold_q    <= '0;
         rr_ptr    <= SRC_W'(NUM_UNITS - 1);
      end else if (load) begin
         out_valid <= 1'b1;
         hold_q    <= '{id: sel_id, payload: sel_payload, src: grant};
         rr_ptr    <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_UNITS; i++) wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (!req_done[i] || req_ack[i]) wait_cnt[i] <= '0;
            else if (wait_cnt[i] != LIMIT) wait_cnt[i] <= wait_cnt[i] + 1'b1;
         end
      end
   end

   assign out_id      = hold_q.id;
   assign out_payload = hold_q.payload;
   assign out_src     = hold_q.src;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: directed stimulus, expected results queued and checked by a separate monitor.
module tb_fp_wb_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [3:0]   req_done, req_ack;
   logic [11:0]  req_id;
   logic [319:0] req_payload;
   logic         out_valid, out_ready, starve_active;
   logic [2:0]   out_id;
   logic [79:0]  out_payload;
   logic [1:0]   out_src;

   logic [3:0]   s_req_done, s_req_ack;
   logic [11:0]  s_req_id;
   logic [319:0] s_req_payload;
   logic         s_out_valid, s_out_ready, s_starve_active;
   logic [2:0]   s_out_id;
   logic [79:0]  s_out_payload;
   logic [1:0]   s_out_src;

   fp_wb_arbiter dut (
      .clk(clk), .rst(rst), .req_done(req_done), .req_id(req_id), .req_payload(req_payload),
      .req_ack(req_ack), .out_valid(out_valid), .out_id(out_id), .out_payload(out_payload),
      .out_src(out_src), .out_ready(out_ready), .starve_active(starve_active)
   );

   fp_wb_arbiter #(.STARVE_LIMIT(2)) dut_s (
      .clk(clk), .rst(rst), .req_done(s_req_done), .req_id(s_req_id), .req_payload(s_req_payload),
      .req_ack(s_req_ack), .out_valid(s_out_valid), .out_id(s_out_id), .out_payload(s_out_payload),
      .out_src(s_out_src), .out_ready(s_out_ready), .starve_active(s_starve_active)
   );

   typedef struct {
      logic [2:0]  id;
      logic [79:0] pl;
      logic [1:0]  src;
   } exp_t;

   exp_t exp_q[$];
   int   tag[4];
   int   n_pass = 0;
   int   n_chk  = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [79:0] payload_of(input int u, input int t);
      return {8'(u + 8'hA0), 72'(t)};
   endfunction

   // unit u always carries id u+3 (unit 2 -> id 5)
   task automatic exp_push(input int u);
      exp_t e;
      e.id  = 3'(u + 3);
      e.pl  = payload_of(u, tag[u]);
      e.src = 2'(u);
      exp_q.push_back(e);
      tag[u]++;
   endtask

   task automatic refresh();
      for (int u = 0; u < 4; u++) req_payload[u*80 +: 80] = payload_of(u, tag[u]);
   endtask

   task automatic cyc(input logic [3:0] done, input logic rdy);
      @(posedge clk);
      #1;
      req_done  = done;
      out_ready = rdy;
      refresh();
      @(negedge clk);
   endtask

   task automatic scyc(input logic [3:0] done, input logic rdy);
      @(posedge clk);
      #1;
      s_req_done  = done;
      s_out_ready = rdy;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         chk("sb_expected_present", 96'(exp_q.size() != 0), 96'(1));
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_out_id", 96'(out_id), 96'(e.id));
            chk("sb_out_payload", 96'(out_payload), 96'(e.pl));
            chk("sb_out_src", 96'(out_src), 96'(e.src));
         end
      end
   end

   initial begin
      for (int u = 0; u < 4; u++) tag[u] = 0;
      rst           = 1'b0;
      req_done      = 4'b0001;
      out_ready     = 1'b0;
      req_id        = {3'd6, 3'd5, 3'd4, 3'd3};
      refresh();
      s_req_done    = 4'b0000;
      s_out_ready   = 1'b0;
      s_req_id      = {3'd6, 3'd5, 3'd4, 3'd3};
      s_req_payload = {4{80'h1234_5678_9ABC_DEF0_1357}};

      // reset held for 3 cycles with a request pending
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", 96'(req_ack), 96'(0));
      chk("rst_out_valid", 96'(out_valid), 96'(0));
      chk("rst_out_id", 96'(out_id), 96'(0));
      chk("rst_out_payload", 96'(out_payload), 96'(0));
      chk("rst_out_src", 96'(out_src), 96'(0));

      @(posedge clk);
      #1;
      rst      = 1'b1;
      req_done = 4'b0000;
      @(negedge clk);

      // single request from unit 2
      cyc(4'b0100, 1'b0);
      chk("single_ack", 96'(req_ack), 96'(4'b0100));
      exp_push(2);
      cyc(4'b0000, 1'b1);
      chk("single_valid", 96'(out_valid), 96'(1));
      chk("single_id", 96'(out_id), 96'(5));
      chk("single_src", 96'(out_src), 96'(2));
      cyc(4'b0000, 1'b1);
      chk("single_drained", 96'(out_valid), 96'(0));

      // drain and load in the same edge
      cyc(4'b0100, 1'b1);
      chk("dl_ack2", 96'(req_ack), 96'(4'b0100));
      exp_push(2);
      cyc(4'b1000, 1'b1);
      chk("dl_ack3", 96'(req_ack), 96'(4'b1000));
      chk("dl_valid", 96'(out_valid), 96'(1));
      chk("dl_src2", 96'(out_src), 96'(2));
      exp_push(3);

      // round robin with all four requesting
      for (int k = 0; k < 6; k++) begin
         cyc(4'b1111, 1'b1);
         chk("rr_valid", 96'(out_valid), 96'(1));
         if (k == 0) chk("dl_no_bubble_src", 96'(out_src), 96'(3));
         chk("rr_ack", 96'(req_ack), 96'(4'b0001 << (k % 4)));
         exp_push(k % 4);
      end

      // backpressure: held unit-1 result, units 0 and 1 pending
      for (int k = 0; k < 5; k++) begin
         cyc(4'b0011, 1'b0);
         chk("bp_ack", 96'(req_ack), 96'(0));
         chk("bp_valid", 96'(out_valid), 96'(1));
         chk("bp_payload", 96'(out_payload), 96'(payload_of(1, tag[1] - 1)));
      end
      cyc(4'b0011, 1'b1);
      chk("bp_release_ack", 96'(req_ack), 96'(4'b0001));
      exp_push(0);
      cyc(4'b0010, 1'b1);
      chk("bp_next_ack", 96'(req_ack), 96'(4'b0010));
      exp_push(1);
      cyc(4'b0000, 1'b1);
      chk("bp_tail_valid", 96'(out_valid), 96'(1));
      cyc(4'b0000, 1'b1);
      chk("bp_empty", 96'(out_valid), 96'(0));

      // asynchronous reset while a result is held and counters run
      cyc(4'b0001, 1'b1);
      chk("ar_load_ack", 96'(req_ack), 96'(4'b0001));
      exp_push(0);
      cyc(4'b0110, 1'b0);
      chk("ar_stall_ack", 96'(req_ack), 96'(0));
      cyc(4'b0110, 1'b0);
      chk("ar_cnt1_before", 96'(dut.wait_cnt[1]), 96'(1));
      chk("ar_valid_before", 96'(out_valid), 96'(1));
      #2;
      exp_q.delete();
      rst = 1'b0;
      #1;
      chk("ar_valid_now", 96'(out_valid), 96'(0));
      chk("ar_cnt1_now", 96'(dut.wait_cnt[1]), 96'(0));
      chk("ar_cnt2_now", 96'(dut.wait_cnt[2]), 96'(0));
      chk("ar_ack_in_rst", 96'(req_ack), 96'(0));
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_done  = 4'b1111;
      out_ready = 1'b1;
      @(negedge clk);
      chk("ar_post_valid", 96'(out_valid), 96'(0));
      chk("ar_post_ack", 96'(req_ack), 96'(4'b0001));
      exp_push(0);
      cyc(4'b0000, 1'b1);
      chk("ar_post_src", 96'(out_src), 96'(0));
      cyc(4'b0000, 1'b0);
      chk("ar_post_empty", 96'(out_valid), 96'(0));

      // starvation escalation on the STARVE_LIMIT=2 instance
      scyc(4'b1000, 1'b1);
      chk("st_prime_ack", 96'(s_req_ack), 96'(4'b1000));
      for (int k = 0; k < 3; k++) begin
         scyc(4'b1000, 1'b0);
         chk("st_stall_ack", 96'(s_req_ack), 96'(0));
         chk("st_stall_starve", 96'(s_starve_active), 96'(0));
      end
      chk("st_cnt3_sat", 96'(dut_s.wait_cnt[3]), 96'(2));
      scyc(4'b1001, 1'b1);
      chk("st_esc_ack", 96'(s_req_ack), 96'(4'b1000));
      chk("st_esc_active", 96'(s_starve_active), 96'(1));
      scyc(4'b0001, 1'b1);
      chk("st_cnt3_clear", 96'(dut_s.wait_cnt[3]), 96'(0));
      chk("st_src3", 96'(s_out_src), 96'(3));
      chk("st_next_ack", 96'(s_req_ack), 96'(4'b0001));
      chk("st_next_normal", 96'(s_starve_active), 96'(0));
      scyc(4'b0000, 1'b1);

      chk("sb_all_consumed", 96'(exp_q.size()), 96'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
